// File: rtl/led_pattern_sequencer_pkg.sv
// Shared definitions for the LED pattern sequencer.
// Holds the config register offsets, the pattern mode encodings and the
// sequencer FSM state encoding used by the top and the testbench.
package led_seq_pkg;

  // Config slave register word offsets
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_SEED   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // Pattern generation modes (CTRL[2:1])
  typedef enum logic [1:0] {
    MODE_ROT    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_COUNT  = 2'd2,
    MODE_STATIC = 2'd3
  } mode_e;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    WRITE     = 2'd2,
    CLEAR     = 2'd3
  } state_e;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Avalon-MM bus bundle used for both sides of the LED pattern sequencer.
// Signals: address, chipselect, write_n (active low), writedata, readdata,
// waitrequest. The master modport drives the request side; the slave modport
// answers with readdata and waitrequest.
interface led_pattern_sequencer_if #(
  parameter int AW = 2,
  parameter int DW = 32
);
  logic [AW-1:0] address;
  logic          chipselect;
  logic          write_n;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          waitrequest;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/led_pattern_sequencer_tick_gen.sv
// Step-period counter for the LED pattern sequencer.
// Ports: clk, reset (sync, active high), clear (restart count at 0),
// hold (freeze count, suppress tick), period (count length), tick (one-cycle
// pulse on terminal count while not held).
module led_seq_tick_gen #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                hold,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

  logic [PERIOD_W-1:0] count_r;
  logic                terminal_s;

  // Terminal count detect; periods 0 and 1 both end every cycle. The >= form
  // keeps a stale count from running past a shortened period.
  always_comb begin
    if (period <= ONE) begin
      terminal_s = 1'b1;
    end else begin
      terminal_s = (count_r >= (period - ONE));
    end
  end

  assign tick = terminal_s & ~hold;

  // Period counter: clear wins, hold freezes, otherwise count and wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (hold) begin
      count_r <= count_r;
    end else if (terminal_s) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + ONE;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Autonomous LED pattern engine.
// Ports: clk, reset (sync, active high);
//   cfg : Avalon-MM slave, CPU programs CTRL/PERIOD/SEED and reads STATUS
//         (zero wait states, readdata combinational from address);
//   pio : Avalon-MM master, writes the pattern to offset 0 of the LED PIO.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int                  WIDTH      = 8,
  parameter int                  PERIOD_W   = 32,
  parameter logic [PERIOD_W-1:0] PERIOD_RST = 32'd50000000
) (
  input  logic                    clk,
  input  logic                    reset,
  led_pattern_sequencer_if.slave  cfg,
  led_pattern_sequencer_if.master pio
);

  localparam logic [WIDTH-1:0] PAT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic                enable_r;
  mode_e               mode_r;
  logic [PERIOD_W-1:0] period_r;
  logic [WIDTH-1:0]    seed_r;
  logic [WIDTH-1:0]    pat_r;
  logic                dir_up_r;
  state_e              state_r;
  logic                m_cs_r;
  logic                m_wn_r;
  logic [31:0]         m_wd_r;

  logic                cfg_wr_s;
  logic                period_wr_s;
  logic                tick_s;
  logic                cnt_clear_s;
  logic                cnt_hold_s;
  logic [WIDTH-1:0]    next_pat_s;
  logic                next_dir_s;
  logic [31:0]         rd_s;
  logic                pio_rd_unused_s;

  assign cfg_wr_s        = cfg.chipselect & ~cfg.write_n;
  assign period_wr_s     = cfg_wr_s & (cfg.address == REG_PERIOD);
  assign pio_rd_unused_s = ^pio.readdata;

  // Config register file; STATUS offset is read-only
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_r <= 1'b0;
      mode_r   <= MODE_ROT;
      period_r <= PERIOD_RST;
      seed_r   <= PAT_ONE;
    end else if (cfg_wr_s) begin
      case (cfg.address)
        REG_CTRL: begin
          enable_r <= cfg.writedata[0];
          mode_r   <= mode_e'(cfg.writedata[2:1]);
        end
        REG_PERIOD: period_r <= cfg.writedata[PERIOD_W-1:0];
        REG_SEED:   seed_r   <= cfg.writedata[WIDTH-1:0];
        default:    ;
      endcase
    end
  end

  // Read mux, combinational from address
  always_comb begin
    rd_s = 32'd0;
    case (cfg.address)
      REG_CTRL:   rd_s[2:0] = {mode_r, enable_r};
      REG_PERIOD: rd_s[PERIOD_W-1:0] = period_r;
      REG_SEED:   rd_s[WIDTH-1:0] = seed_r;
      REG_STATUS: begin
        rd_s[0]          = (state_r != IDLE);
        rd_s[8 +: WIDTH] = pat_r;
      end
      default:    rd_s = 32'd0;
    endcase
  end

  assign cfg.readdata    = rd_s;
  assign cfg.waitrequest = 1'b0;

  // Next pattern for the current mode; bounce flips direction on the end bit
  // itself so that end bit is shown only once
  always_comb begin
    next_pat_s = pat_r;
    next_dir_s = dir_up_r;
    case (mode_r)
      MODE_ROT:    next_pat_s = {pat_r[WIDTH-2:0], pat_r[WIDTH-1]};
      MODE_BOUNCE: begin
        if (dir_up_r) begin
          if (pat_r[WIDTH-1]) begin
            next_pat_s = {1'b0, pat_r[WIDTH-1:1]};
            next_dir_s = 1'b0;
          end else begin
            next_pat_s = {pat_r[WIDTH-2:0], 1'b0};
          end
        end else begin
          if (pat_r[0]) begin
            next_pat_s = {pat_r[WIDTH-2:0], 1'b0};
            next_dir_s = 1'b1;
          end else begin
            next_pat_s = {1'b0, pat_r[WIDTH-1:1]};
          end
        end
      end
      MODE_COUNT:  next_pat_s = pat_r + PAT_ONE;
      MODE_STATIC: next_pat_s = seed_r;
      default:     next_pat_s = pat_r;
    endcase
  end

  // Counter only runs while waiting; it restarts on enable, on PERIOD writes
  // and on write completion so each period is measured from the accepted write
  always_comb begin
    cnt_hold_s = (state_r != WAIT_TICK);
    if (period_wr_s) begin
      cnt_clear_s = 1'b1;
    end else if ((state_r == IDLE) && enable_r) begin
      cnt_clear_s = 1'b1;
    end else if ((state_r == WRITE) && !pio.waitrequest) begin
      cnt_clear_s = 1'b1;
    end else begin
      cnt_clear_s = 1'b0;
    end
  end

  led_seq_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear_s),
    .hold   (cnt_hold_s),
    .period (period_r),
    .tick   (tick_s)
  );

  // Sequencer FSM with registered master outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      pat_r    <= '0;
      dir_up_r <= 1'b1;
      m_cs_r   <= 1'b0;
      m_wn_r   <= 1'b1;
      m_wd_r   <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enable_r) begin
            pat_r    <= seed_r;
            dir_up_r <= 1'b1;
            m_cs_r   <= 1'b1;
            m_wn_r   <= 1'b0;
            m_wd_r   <= {{(32-WIDTH){1'b0}}, seed_r};
            state_r  <= WRITE;
          end
        end
        WAIT_TICK: begin
          if (!enable_r) begin
            state_r <= CLEAR;
          end else if (tick_s) begin
            pat_r    <= next_pat_s;
            dir_up_r <= next_dir_s;
            m_cs_r   <= 1'b1;
            m_wn_r   <= 1'b0;
            m_wd_r   <= {{(32-WIDTH){1'b0}}, next_pat_s};
            state_r  <= WRITE;
          end
        end
        WRITE: begin
          // enable is only consulted once the in-flight write is accepted
          if (!pio.waitrequest) begin
            m_cs_r  <= 1'b0;
            m_wn_r  <= 1'b1;
            state_r <= enable_r ? WAIT_TICK : CLEAR;
          end
        end
        CLEAR: begin
          // first CLEAR cycle launches the blanking write, then wait for accept
          if (!m_cs_r) begin
            m_cs_r <= 1'b1;
            m_wn_r <= 1'b0;
            m_wd_r <= 32'd0;
          end else if (!pio.waitrequest) begin
            m_cs_r  <= 1'b0;
            m_wn_r  <= 1'b1;
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign pio.address    = '0;
  assign pio.chipselect = m_cs_r;
  assign pio.write_n    = m_wn_r;
  assign pio.writedata  = m_wd_r;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: a negedge monitor records
// every PIO write start and acceptance; expected patterns come from a
// closed-form model of each mode.
module tb_led_pattern_sequencer;
  import led_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  led_pattern_sequencer_if cfg_bus ();
  led_pattern_sequencer_if pio_bus ();

  led_pattern_sequencer #(
    .WIDTH(8), .PERIOD_W(32), .PERIOD_RST(32'd50000000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cfg   (cfg_bus),
    .pio   (pio_bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  int unsigned cyc = 0;
  logic        prev_cs = 1'b0;
  logic [31:0] acc_data_q[$];
  int unsigned acc_cyc_q[$];
  int unsigned start_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      prev_cs <= 1'b0;
    end else begin
      if (pio_bus.chipselect && !pio_bus.write_n) begin
        if (!prev_cs) start_cyc_q.push_back(cyc);
        if (!pio_bus.waitrequest) begin
          acc_data_q.push_back(pio_bus.writedata);
          acc_cyc_q.push_back(cyc);
        end
      end
      prev_cs <= pio_bus.chipselect && !pio_bus.write_n;
    end
  end

  // Reference: the i-th pattern written after enabling with the given seed
  function automatic logic [7:0] model_pat(input int mode, input logic [7:0] seed, input int i);
    int s, r, k, j;
    s = int'(seed);
    case (mode)
      0: begin
        r = i % 8;
        model_pat = 8'(((s << r) | (s >> (8 - r))) & 255);
      end
      1: begin
        k = 0;
        for (int b = 0; b < 8; b++) if (seed[b]) k = b;
        j = (k + i) % 14;
        model_pat = 8'(1 << ((j < 8) ? j : (14 - j)));
      end
      2: model_pat = 8'((s + i) % 256);
      default: model_pat = seed;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_bus.address = a; cfg_bus.writedata = d;
    cfg_bus.chipselect = 1'b1; cfg_bus.write_n = 1'b0;
    step(1);
    cfg_bus.chipselect = 1'b0; cfg_bus.write_n = 1'b1;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_bus.address = a;
    #1;
    d = cfg_bus.readdata;
  endtask

  task automatic clear_mon();
    acc_data_q.delete(); acc_cyc_q.delete(); start_cyc_q.delete();
  endtask

  task automatic wait_acc(input int n, input int budget, output bit ok);
    int k = 0;
    while (acc_data_q.size() < n && k < budget) begin step(1); k++; end
    ok = (acc_data_q.size() >= n);
  endtask

  task automatic wait_cs(input int budget, output bit ok);
    int k = 0;
    while (!pio_bus.chipselect && k < budget) begin step(1); k++; end
    ok = pio_bus.chipselect;
  endtask

  task automatic stop_dut(output bit ok);
    logic [31:0] st;
    int k = 0;
    pio_bus.waitrequest = 1'b0;
    cfg_write(REG_CTRL, 32'd0);
    cfg_read(REG_STATUS, st);
    while (st[0] && k < 100) begin step(1); cfg_read(REG_STATUS, st); k++; end
    ok = !st[0];
    step(1);
    clear_mon();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; step(3); reset = 1'b0; clear_mon(); step(1);
    cfg_read(REG_STATUS, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %0h expected 0", d); end
    cfg_read(REG_CTRL, d);
    tests_run++; if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %0h expected 0", d); end
    cfg_read(REG_PERIOD, d);
    tests_run++; if (d !== 32'd50000000) begin tests_failed++; $display("FAIL reset_period: got %0d expected 50000000", d); end
    cfg_read(REG_SEED, d);
    tests_run++; if (d !== 32'h1) begin tests_failed++; $display("FAIL reset_seed: got %0h expected 1", d); end
    step(20);
    tests_run++;
    if (start_cyc_q.size() != 0 || pio_bus.chipselect !== 1'b0 || pio_bus.write_n !== 1'b1 || pio_bus.writedata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_idle_master: got starts=%0d cs=%b wn=%b wd=%0h expected none/0/1/0",
               start_cyc_q.size(), pio_bus.chipselect, pio_bus.write_n, pio_bus.writedata);
    end
  endtask

  task automatic test_rotate();
    bit ok;
    cfg_write(REG_PERIOD, 32'd4); cfg_write(REG_SEED, 32'h81); clear_mon();
    cfg_write(REG_CTRL, 32'h1);
    wait_acc(4, 100, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL rotate_timeout: got %0d writes expected 4", acc_data_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (acc_data_q[i] !== {24'd0, model_pat(0, 8'h81, i)}) begin
          tests_failed++; $display("FAIL rotate_data[%0d]: got %0h expected %0h", i, acc_data_q[i], model_pat(0, 8'h81, i));
        end
      end
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (acc_cyc_q[i+1] - acc_cyc_q[i] != 5) begin
          tests_failed++; $display("FAIL rotate_spacing[%0d]: got %0d expected 5", i, acc_cyc_q[i+1] - acc_cyc_q[i]);
        end
      end
    end
    stop_dut(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL rotate_stop: got busy expected idle"); end
  endtask

  task automatic test_bounce();
    bit ok;
    cfg_write(REG_PERIOD, 32'd1); cfg_write(REG_SEED, 32'h01); clear_mon();
    cfg_write(REG_CTRL, 32'h3);
    wait_acc(17, 200, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL bounce_timeout: got %0d writes expected 17", acc_data_q.size()); end
    else begin
      for (int i = 0; i < 17; i++) begin
        tests_run++;
        if (acc_data_q[i] !== {24'd0, model_pat(1, 8'h01, i)}) begin
          tests_failed++; $display("FAIL bounce_data[%0d]: got %0h expected %0h", i, acc_data_q[i], model_pat(1, 8'h01, i));
        end
      end
      for (int i = 0; i < 16; i++) begin
        tests_run++;
        if (acc_data_q[i] == acc_data_q[i+1]) begin
          tests_failed++; $display("FAIL bounce_repeat[%0d]: got %0h twice expected change", i, acc_data_q[i]);
        end
      end
    end
    stop_dut(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL bounce_stop: got busy expected idle"); end
  endtask

  task automatic test_count();
    bit ok;
    cfg_write(REG_SEED, 32'hFE); cfg_write(REG_PERIOD, 32'd1); clear_mon();
    cfg_write(REG_CTRL, 32'h5);
    wait_acc(4, 100, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL count_timeout: got %0d writes expected 4", acc_data_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (acc_data_q[i] !== {24'd0, model_pat(2, 8'hFE, i)}) begin
          tests_failed++; $display("FAIL count_data[%0d]: got %0h expected %0h", i, acc_data_q[i], model_pat(2, 8'hFE, i));
        end
      end
    end
    stop_dut(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL count_stop: got busy expected idle"); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [7:0]  seed;
    logic [35:0] snap, exp_snap;
    seed = 8'($urandom_range(1, 255));
    cfg_write(REG_PERIOD, 32'd4); cfg_write(REG_SEED, {24'd0, seed}); clear_mon();
    cfg_write(REG_CTRL, 32'h1);
    wait_acc(1, 100, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL stall_first: got no write expected 1"); end
    pio_bus.waitrequest = 1'b1; clear_mon();
    wait_cs(50, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL stall_start: got cs=0 expected 1"); end
    else begin
      exp_snap = {2'b00, 1'b1, 1'b0, 24'd0, model_pat(0, seed, 1)};
      for (int c = 0; c < 4; c++) begin
        snap = {pio_bus.address, pio_bus.chipselect, pio_bus.write_n, pio_bus.writedata};
        tests_run++;
        if (snap !== exp_snap || acc_data_q.size() != 0) begin
          tests_failed++; $display("FAIL stall_stable[%0d]: got %0h acc=%0d expected %0h acc=0", c, snap, acc_data_q.size(), exp_snap);
        end
        if (c < 3) step(1);
      end
      pio_bus.waitrequest = 1'b0;
      step(1);
      tests_run++;
      if (pio_bus.chipselect !== 1'b0 || pio_bus.write_n !== 1'b1 || acc_data_q.size() != 1) begin
        tests_failed++; $display("FAIL stall_single_accept: got cs=%b wn=%b acc=%0d expected 0/1/1",
                                 pio_bus.chipselect, pio_bus.write_n, acc_data_q.size());
      end
      wait_cs(50, ok);
      step(1);
      tests_run++;
      if (start_cyc_q.size() < 2 || acc_cyc_q.size() < 1) begin
        tests_failed++; $display("FAIL stall_next: got starts=%0d expected 2", start_cyc_q.size());
      end else if (start_cyc_q[1] - acc_cyc_q[0] != 5) begin
        tests_failed++; $display("FAIL stall_next: got gap %0d expected 5", start_cyc_q[1] - acc_cyc_q[0]);
      end
    end
    stop_dut(ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL stall_stop: got busy expected idle"); end
  endtask

  task automatic test_disable_mid_write();
    bit ok;
    logic [7:0]  seed, p1;
    logic [31:0] st;
    int k;
    seed = 8'($urandom_range(1, 255));
    p1 = model_pat(0, seed, 1);
    cfg_write(REG_PERIOD, 32'd3); cfg_write(REG_SEED, {24'd0, seed}); clear_mon();
    cfg_write(REG_CTRL, 32'h1);
    wait_acc(1, 100, ok);
    pio_bus.waitrequest = 1'b1;
    wait_cs(50, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL disable_start: got cs=0 expected 1"); end
    clear_mon();
    cfg_write(REG_CTRL, 32'h0);
    step(1);
    tests_run++;
    if (pio_bus.chipselect !== 1'b1 || pio_bus.write_n !== 1'b0 || pio_bus.writedata !== {24'd0, p1}) begin
      tests_failed++; $display("FAIL disable_inflight: got cs=%b wn=%b wd=%0h expected 1/0/%0h",
                               pio_bus.chipselect, pio_bus.write_n, pio_bus.writedata, p1);
    end
    pio_bus.waitrequest = 1'b0;
    wait_acc(2, 50, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL disable_writes: got %0d writes expected 2", acc_data_q.size()); end
    else if (acc_data_q[0] !== {24'd0, p1} || acc_data_q[1] !== 32'h0) begin
      tests_failed++; $display("FAIL disable_writes: got %0h,%0h expected %0h,0", acc_data_q[0], acc_data_q[1], p1);
    end
    k = 0;
    cfg_read(REG_STATUS, st);
    while (st[0] && k < 50) begin step(1); cfg_read(REG_STATUS, st); k++; end
    tests_run++;
    if (st !== {16'd0, p1, 8'd0}) begin
      tests_failed++; $display("FAIL disable_status: got %0h expected %0h", st, {16'd0, p1, 8'd0});
    end
    step(1); clear_mon();
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    logic [31:0] st;
    cfg_write(REG_PERIOD, 32'd2); cfg_write(REG_SEED, 32'h5A); clear_mon();
    cfg_write(REG_CTRL, 32'h1);
    wait_acc(1, 100, ok);
    pio_bus.waitrequest = 1'b1;
    wait_cs(50, ok);
    reset = 1'b1;
    step(1);
    tests_run++;
    if (pio_bus.chipselect !== 1'b0 || pio_bus.write_n !== 1'b1 || pio_bus.writedata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_mid_write: got cs=%b wn=%b wd=%0h expected 0/1/0",
                               pio_bus.chipselect, pio_bus.write_n, pio_bus.writedata);
    end
    reset = 1'b0; pio_bus.waitrequest = 1'b0; clear_mon();
    step(10);
    cfg_read(REG_STATUS, st);
    tests_run++;
    if (st !== 32'h0 || acc_data_q.size() != 0) begin
      tests_failed++; $display("FAIL reset_mid_after: got status=%0h writes=%0d expected 0/0", st, acc_data_q.size());
    end
  endtask

  task automatic test_random();
    bit ok;
    int mode, per, peff, k;
    logic [7:0] seed;
    for (int it = 0; it < 4; it++) begin
      mode = $urandom_range(0, 3);
      per  = $urandom_range(0, 5);
      peff = (per <= 1) ? 1 : per;
      if (mode == 1) seed = 8'h01 << $urandom_range(0, 7);
      else           seed = 8'($urandom_range(0, 255));
      cfg_write(REG_PERIOD, 32'(per)); cfg_write(REG_SEED, {24'd0, seed}); clear_mon();
      cfg_write(REG_CTRL, 32'(mode * 2 + 1));
      k = 0;
      while (acc_data_q.size() < 8 && k < 600) begin
        pio_bus.waitrequest = ($urandom_range(0, 2) == 0);
        step(1); k++;
      end
      pio_bus.waitrequest = 1'b0;
      tests_run++;
      if (acc_data_q.size() < 8) begin
        tests_failed++; $display("FAIL random_timeout[%0d]: got %0d writes expected 8", it, acc_data_q.size());
      end else begin
        for (int i = 0; i < 8; i++) begin
          tests_run++;
          if (acc_data_q[i] !== {24'd0, model_pat(mode, seed, i)}) begin
            tests_failed++; $display("FAIL random_data[%0d.%0d]: mode %0d got %0h expected %0h",
                                     it, i, mode, acc_data_q[i], model_pat(mode, seed, i));
          end
        end
        for (int i = 0; i < 7; i++) begin
          tests_run++;
          if (start_cyc_q[i+1] - acc_cyc_q[i] != peff + 1) begin
            tests_failed++; $display("FAIL random_gap[%0d.%0d]: got %0d expected %0d",
                                     it, i, start_cyc_q[i+1] - acc_cyc_q[i], peff + 1);
          end
        end
      end
      stop_dut(ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL random_stop[%0d]: got busy expected idle", it); end
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_bus.address = 2'd0; cfg_bus.chipselect = 1'b0; cfg_bus.write_n = 1'b1; cfg_bus.writedata = 32'd0;
    pio_bus.waitrequest = 1'b0; pio_bus.readdata = 32'd0;
    test_reset();
    test_rotate();
    test_bounce();
    test_count();
    test_stall();
    test_disable_mid_write();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
